// File: rtl/branch_offset_encoder.sv
// Two-stage encoder from (PC, absolute target) to a MIPS imm16 or index26 field.
// Optional macro ALIGN_CHECK_EN enables the target alignment flag.
module branch_offset_encoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_target,
    input  logic             in_jump,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [25:0]      out_field,
    output logic             out_ovf,
    output logic             out_misalign,
    output logic [CNT_W-1:0] err_cnt
);

    logic             s1_adv;
    logic             s2_adv;
    logic             out_hs;
    logic             err_flag;

    logic             s1_valid_q;
    logic             s1_jump_q;
    logic [31:2]      s1_tgt_q;
    logic [31:0]      s1_diff_q;
    logic [3:0]       s1_pc4hi_q;

    logic [31:0]      pc4_d;
    logic [31:0]      diff_d;

    logic [31:0]      off;
    logic [25:0]      field_d;
    logic             ovf_d;

    logic             out_valid_q;
    logic [25:0]      out_field_q;
    logic             out_ovf_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] err_cnt_d;

    // Stage 2 is the output register, so its valid is out_valid itself.
    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;
    assign out_hs   = out_valid_q && out_ready;

    assign pc4_d  = in_pc + 32'd4;
    assign diff_d = in_target - pc4_d;

    always_comb begin
        off     = $signed(s1_diff_q) >>> 2;
        field_d = '0;
        ovf_d   = 1'b0;
        if (s1_jump_q) begin
            field_d = s1_tgt_q[27:2];
            ovf_d   = (s1_tgt_q[31:28] != s1_pc4hi_q);
        end else begin
            field_d = {10'b0, off[15:0]};
            ovf_d   = !((&off[31:15]) || !(|off[31:15]));
        end
    end

`ifdef ALIGN_CHECK_EN
    logic s1_mis_q;
    logic out_mis_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_mis_q  <= 1'b0;
            out_mis_q <= 1'b0;
        end else begin
            if (s1_adv && in_valid) begin
                s1_mis_q <= (in_target[1:0] != 2'b00);
            end
            if (s2_adv && s1_valid_q) begin
                out_mis_q <= s1_mis_q;
            end
        end
    end

    assign out_misalign = out_mis_q;
    assign err_flag     = out_ovf_q | out_mis_q;
`else
    assign out_misalign = 1'b0;
    assign err_flag     = out_ovf_q;
`endif

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (out_hs && err_flag && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_jump_q   <= 1'b0;
            s1_tgt_q    <= '0;
            s1_diff_q   <= '0;
            s1_pc4hi_q  <= '0;
            out_valid_q <= 1'b0;
            out_field_q <= '0;
            out_ovf_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_jump_q  <= in_jump;
                    s1_tgt_q   <= in_target[31:2];
                    s1_diff_q  <= diff_d;
                    s1_pc4hi_q <= pc4_d[31:28];
                end
            end
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_field_q <= field_d;
                    out_ovf_q   <= ovf_d;
                end
            end
            err_cnt_q <= err_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_field = out_field_q;
    assign out_ovf   = out_ovf_q;
    assign err_cnt   = err_cnt_q;

endmodule
